kvosic_counter: RTL and testbench

- 4-bit up/down counter with synchronous load, wrap flag and compare-match output, packaged in the standard tile pin interface (ui_in/uo_out/uio_*/ena).
- Top-level user block of the chip tile. All logic is in one clock domain.
- Control comes from the dedicated inputs. The compare value comes from the bidirectional inputs, which are always configured as inputs.

---
 rtl/kvosic_counter.sv | 150 +++++++++++++++
 tb/tb_kvosic_counter.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/kvosic_counter.sv
// rtl/kvosic_counter.sv - tile-packaged up/down counter with load, wrap flag and compare match
//
// Purpose:
//   WIDTH-bit up/down counter with a synchronous load, a registered wrap flag
//   (tc) and a combinational compare-match output. It is packaged in the
//   standard tile pin interface. Everything runs in the single clk domain.
//
// Optional feature macro: PRESCALE_EN
//   Defined   : a free-running prescaler gates counting to one tick every
//               2^sel enabled cycles (sel = uio_in[6:4]).
//   Undefined : tick is tied to 1, no prescaler flops are built and
//               uio_in[6:4] is ignored.
//
// Ports:
//   clk      in   1  system clock, rising edge
//   rst      in   1  synchronous active-high reset, wins over ena
//   ena      in   1  tile enable; 0 freezes count, tc and prescaler
//   ui_in    in   8  [0] cnt_en, [1] up, [2] load, [3] ignored, [7:4] load value
//   uio_in   in   8  [3:0] compare value, [6:4] prescale select, [7] ignored
//   uo_out   out  8  [3:0] count, [4] tc, [5] match, [6] direction, [7] 0
//   uio_out  out  8  constant 0
//   uio_oe   out  8  constant 0; bidirectional pins are inputs only

module kvosic_counter #(
   parameter int WIDTH      = 4,
   parameter int PRESCALE_W = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   // Decoded control fields
   logic             cnt_en;
   logic             up;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] cmp_val;

   assign cnt_en   = ui_in[0];
   assign up       = ui_in[1];
   assign load     = ui_in[2];
   assign load_val = ui_in[4 +: WIDTH];
   assign cmp_val  = uio_in[WIDTH-1:0];

   // Counter state
   logic [WIDTH-1:0] count;
   logic             tc;
   logic             tick;

   // Next count and whether that step crosses the modulo boundary
   logic [WIDTH-1:0] count_step;
   logic             wraps;

   always_comb begin
      count_step = count;
      wraps      = 1'b0;
      if (up) begin
         count_step = count + ONE;
         wraps      = (count == {WIDTH{1'b1}});
      end else begin
         count_step = count - ONE;
         wraps      = (count == {WIDTH{1'b0}});
      end
   end

`ifdef PRESCALE_EN
   // Prescaler wide enough for the largest select: 2^PRESCALE_W-1 bits.
   localparam int PB = (1 << PRESCALE_W) - 1;

   logic [PB-1:0]         presc;
   logic [PRESCALE_W-1:0] sel_q;
   logic [PB-1:0]         presc_mask;

   // Low sel bits all ones marks the last cycle of each 2^sel window;
   // sel=0 yields an empty mask and therefore a tick every cycle.
   always_comb begin
      presc_mask = '0;
      for (int i = 0; i < PB; i++) begin
         presc_mask[i] = (i < int'(sel_q));
      end
   end

   assign tick = ((presc & presc_mask) == presc_mask);

   // Select is registered so a change takes effect on the following cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         presc <= '0;
         sel_q <= '0;
      end else begin
         sel_q <= uio_in[4 +: PRESCALE_W];
         if (ena) begin
            if (load) begin
               presc <= '0;
            end else if (cnt_en) begin
               presc <= presc + PB'(1);
            end
         end
      end
   end
`else
   assign tick = 1'b1;
`endif

   // Counter and wrap flag: load > count > hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         tc    <= 1'b0;
      end else if (ena) begin
         if (load) begin
            count <= load_val;
            tc    <= 1'b0;
         end else if (cnt_en && tick) begin
            count <= count_step;
            tc    <= wraps;
         end else begin
            tc    <= 1'b0;
         end
      end
   end

   // Zero-extend the count onto the 4-bit output field.
   logic [3:0] count_ext;

   always_comb begin
      count_ext              = '0;
      count_ext[WIDTH-1:0]   = count;
   end

   logic match;
   assign match = (count == cmp_val);

   assign uo_out  = {1'b0, up, match, tc, count_ext};
   assign uio_out = 8'h00;
   assign uio_oe  = 8'h00;

   // Reserved and (build-dependent) ignored input bits.
   logic unused_inputs;
   assign unused_inputs = ^{ui_in, uio_in};

endmodule

// File: tb/tb_kvosic_counter.sv
// tb/tb_kvosic_counter.sv - scoreboard bench for kvosic_counter
module tb_kvosic_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ena = 1'b0;
   logic [7:0] ui_in  = 8'h00;
   logic [7:0] uio_in = 8'h00;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int checks = 0;
   int errors = 0;
   int step_no = 0;

   typedef struct {
      int         id;
      logic [3:0] count;
      logic       tc;
      logic       match;
      logic       dir;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   kvosic_counter #(.WIDTH(4), .PRESCALE_W(3)) dut (
      .clk     (clk),
      .rst     (rst),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   // Apply one cycle of inputs and queue the state expected after the edge.
   task automatic step(input logic [7:0] ui, input logic [7:0] uio,
                       input logic e, input logic r,
                       input logic [3:0] ec, input logic et);
      exp_t x;
      @(negedge clk);
      ui_in  = ui;
      uio_in = uio;
      ena    = e;
      rst    = r;
      x.id    = step_no;
      x.count = ec;
      x.tc    = et;
      x.match = (ec == uio[3:0]);
      x.dir   = ui[1];
      sb.push_back(x);
      step_no++;
   endtask

   // Monitor: one scoreboard entry is due just after each rising edge.
   initial begin
      exp_t e;
      logic [7:0] want;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            want = {1'b0, e.dir, e.match, e.tc, e.count};
            checks++;
            if (uo_out !== want) begin
               errors++;
               $display("FAIL uo_out step %0d: got %h want %h", e.id, uo_out, want);
            end
            checks++;
            if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
               errors++;
               $display("FAIL uio_const step %0d: uio_out %h uio_oe %h want 00 00",
                        e.id, uio_out, uio_oe);
            end
         end
      end
   end

   initial begin
      // Reset with arbitrary inputs; second cycle shows rst beats ena=0.
      step(8'hA5, 8'h3C, 1'b1, 1'b1, 4'd0, 1'b0);
      step(8'hA7, 8'h3C, 1'b0, 1'b1, 4'd0, 1'b0);

      // Count up through the wrap.
      for (int i = 1; i <= 16; i++)
         step(8'h03, 8'h00, 1'b1, 1'b0, 4'(i % 16), (i == 16));
      step(8'h03, 8'h00, 1'b1, 1'b0, 4'd1, 1'b0);

      // Load 2, count down through the wrap.
      step(8'h24, 8'h00, 1'b1, 1'b0, 4'd2,  1'b0);
      step(8'h01, 8'h00, 1'b1, 1'b0, 4'd1,  1'b0);
      step(8'h01, 8'h00, 1'b1, 1'b0, 4'd0,  1'b0);
      step(8'h01, 8'h00, 1'b1, 1'b0, 4'd15, 1'b1);
      step(8'h01, 8'h00, 1'b1, 1'b0, 4'd14, 1'b0);

      // Load priority over counting.
      step(8'h54, 8'h00, 1'b1, 1'b0, 4'd5, 1'b0);
      step(8'h97, 8'h00, 1'b1, 1'b0, 4'd9, 1'b0);

      // ena=0 freezes count while cnt_en is asserted; compare matches 9.
      for (int i = 0; i < 10; i++)
         step(8'h03, 8'h09, 1'b0, 1'b0, 4'd9, 1'b0);
      step(8'h00, 8'h08, 1'b1, 1'b0, 4'd9, 1'b0);
      step(8'h00, 8'h09, 1'b1, 1'b0, 4'd9, 1'b0);

      // Direction change applies on the next counting edge.
      step(8'h03, 8'h0A, 1'b1, 1'b0, 4'd10, 1'b0);
      step(8'h01, 8'h0A, 1'b1, 1'b0, 4'd9,  1'b0);

      // tc holds while disabled, clears on the next enabled non-wrap cycle.
      step(8'hF4, 8'h00, 1'b1, 1'b0, 4'd15, 1'b0);
      step(8'h03, 8'h00, 1'b1, 1'b0, 4'd0,  1'b1);
      step(8'h03, 8'h00, 1'b0, 1'b0, 4'd0,  1'b1);
      step(8'h03, 8'h00, 1'b0, 1'b0, 4'd0,  1'b1);
      step(8'h00, 8'h00, 1'b1, 1'b0, 4'd0,  1'b0);

      // Reset mid-count.
      step(8'hA4, 8'h00, 1'b1, 1'b0, 4'd10, 1'b0);
      step(8'h03, 8'h00, 1'b1, 1'b0, 4'd11, 1'b0);
      step(8'h03, 8'h00, 1'b1, 1'b1, 4'd0,  1'b0);
      step(8'h03, 8'h00, 1'b1, 1'b0, 4'd1,  1'b0);

`ifdef PRESCALE_EN
      // sel=2: load clears the prescaler, then one increment per 4 clks.
      step(8'h04, 8'h20, 1'b1, 1'b0, 4'd0, 1'b0);
      for (int i = 1; i <= 12; i++)
         step(8'h03, 8'h20, 1'b1, 1'b0, 4'(i / 4), 1'b0);
`endif

      @(negedge clk);
      ui_in = 8'h00;
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
